twiddle_sched: RTL and testbench

Twiddle-factor scheduler for the radix-2 FFT core. It sequences the pair of 512x16 twiddle ROMs (real cos, imag −sin; Q1.15), which share one read-enable and one address. It streams one twiddle per butterfly, stage by stage, to the butterfly datapath over a valid/ready handshake. During back-pressure it keeps the ROM outputs stable by re-reading the held address, because each ROM output register loads 0 whenever its read-enable is low.

---
 rtl/twiddle_sched.sv | 109 ++++++++++
 tb/tb_twiddle_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_sched.sv
// Twiddle-factor scheduler: streams one ROM twiddle per butterfly over valid/ready, stage by stage.
// Define TWIDDLE_SCHED_DIF_EN for decimation-in-frequency address ordering (DIT otherwise).
module twiddle_sched #(
    parameter int unsigned LOG2N = 10,
    parameter int unsigned AW    = LOG2N - 1,
    parameter int unsigned SW    = $clog2(LOG2N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_tw_ready,
    output logic          o_rom_rd_en,
    output logic [AW-1:0] o_rom_rd_addr,
    output logic          o_tw_valid,
    output logic [SW-1:0] o_tw_stage,
    output logic [AW-1:0] o_tw_idx,
    output logic          o_tw_last,
    output logic          o_busy,
    output logic          o_done
);
    localparam logic [SW-1:0] LAST_S = SW'(LOG2N - 1);
    localparam logic [AW-1:0] LAST_J = AW'((1 << (LOG2N - 1)) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q;
    logic [SW-1:0] s_q;
    logic [AW-1:0] j_q;
    logic [AW-1:0] hold_addr_q;

    logic          adv_c;
    logic          final_c;
    logic [AW:0]   mask_c;
    logic [AW-1:0] addr_c;

    // Twiddle address for the element at the issue counters.
    always_comb begin
        mask_c = '0;
        addr_c = '0;
`ifdef TWIDDLE_SCHED_DIF_EN
        mask_c = ((AW+1)'(1) << (LAST_S - s_q)) - (AW+1)'(1);
        addr_c = (j_q & mask_c[AW-1:0]) << s_q;
`else
        mask_c = ((AW+1)'(1) << s_q) - (AW+1)'(1);
        addr_c = (j_q & mask_c[AW-1:0]) << (LAST_S - s_q);
`endif
    end

    assign adv_c   = !o_tw_valid || i_tw_ready;
    assign final_c = (s_q == LAST_S) && (j_q == LAST_J);
    assign o_busy  = (state_q != IDLE);

    // While stalled, re-read the presented entry so the ROM output register stays stable.
    assign o_rom_rd_en   = adv_c ? (state_q == RUN) : 1'b1;
    assign o_rom_rd_addr = adv_c ? addr_c : hold_addr_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            j_q         <= '0;
            hold_addr_q <= '0;
            o_tw_valid  <= 1'b0;
            o_tw_stage  <= '0;
            o_tw_idx    <= '0;
            o_tw_last   <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (adv_c) begin
                o_tw_valid  <= (state_q == RUN);
                o_tw_stage  <= s_q;
                o_tw_idx    <= j_q;
                o_tw_last   <= final_c;
                hold_addr_q <= addr_c;
            end
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= RUN;
                        s_q     <= '0;
                        j_q     <= '0;
                    end
                end
                RUN: begin
                    if (adv_c) begin
                        if (final_c) begin
                            state_q <= DRAIN;
                            s_q     <= '0;
                            j_q     <= '0;
                        end else if (j_q == LAST_J) begin
                            j_q <= '0;
                            s_q <= s_q + SW'(1);
                        end else begin
                            j_q <= j_q + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (o_tw_valid && i_tw_ready && o_tw_last) begin
                        state_q <= IDLE;
                        o_done  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_twiddle_sched.sv
// Self-checking bench for twiddle_sched: ROM model, sequence model and per-cycle compare.
module tb_twiddle_sched;
    localparam int LOG2N = 10;
    localparam int HALF  = 1 << (LOG2N - 1);
    localparam int TOTAL = LOG2N * HALF;

`ifdef TWIDDLE_SCHED_DIF_EN
    localparam int P0S = 0, P0J = 7, P0A = 7;
    localparam int P1S = 8, P1J = 1, P1A = 256;
    localparam int P2S = 9, P2J = 5, P2A = 0;
`else
    localparam int P0S = 0, P0J = 7, P0A = 0;
    localparam int P1S = 1, P1J = 1, P1A = 256;
    localparam int P2S = 9, P2J = 5, P2A = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic        tw_valid;
    logic [3:0]  tw_stage;
    logic [8:0]  tw_idx;
    logic        tw_last;
    logic        busy;
    logic        done;
    logic [15:0] rom_q;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int exp_idx = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
    int mode = 0, forced = 0, start_cyc = 0, ms = 0, mj = 0, iss = 0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_rom = '0;

    twiddle_sched dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_tw_ready    (ready),
        .o_rom_rd_en   (rd_en),
        .o_rom_rd_addr (rd_addr),
        .o_tw_valid    (tw_valid),
        .o_tw_stage    (tw_stage),
        .o_tw_idx      (tw_idx),
        .o_tw_last     (tw_last),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_addr(input int s, input int j);
`ifdef TWIDDLE_SCHED_DIF_EN
        return (j % (1 << (LOG2N - 1 - s))) << s;
`else
        return (j % (1 << s)) << (LOG2N - 1 - s);
`endif
    endfunction

    function automatic logic [15:0] romf(input int a);
        return 16'((a * 7 + 3) ^ 32'hA5A5);
    endfunction

    // Twiddle ROM: one-cycle latency, output register loads 0 when not enabled.
    always @(posedge clk) rom_q <= rd_en ? romf(int'(rd_addr)) : 16'h0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, tw_valid, 0);
        chk({tag, "_stage"}, tw_stage, 0);
        chk({tag, "_idx"}, tw_idx, 0);
        chk({tag, "_last"}, tw_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
    endtask

    // Per-cycle compare against the sequence model.
    always @(negedge clk) begin
        if (rst) begin
            chk_all_zero("rst");
            exp_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            if (tw_valid) begin
                ms = exp_idx / HALF;
                mj = exp_idx % HALF;
                chk("stage", tw_stage, ms);
                chk("idx", tw_idx, mj);
                chk("last", tw_last, (exp_idx == TOTAL - 1) ? 1 : 0);
                chk("rom_data", rom_q, romf(exp_addr(ms, mj)));
                if (ms == P0S && mj == P0J) chk("pin_a", rom_q, romf(P0A));
                if (ms == P1S && mj == P1J) chk("pin_b", rom_q, romf(P1A));
                if (ms == P2S && mj == P2J) chk("pin_c", rom_q, romf(P2A));
                if (!ready) begin
                    chk("stall_rd_en", rd_en, 1);
                    chk("stall_rd_addr", rd_addr, exp_addr(ms, mj));
                    if (ms == P2S && mj == P2J) chk("stall_pin_addr", rd_addr, P2A);
                end
            end
            if (busy && (!tw_valid || ready)) begin
                iss = exp_idx + (tw_valid ? 1 : 0);
                if (iss < TOTAL) begin
                    chk("issue_rd_en", rd_en, 1);
                    chk("issue_rd_addr", rd_addr, exp_addr(iss / HALF, iss % HALF));
                end else begin
                    chk("drain_rd_en", rd_en, 0);
                end
            end
            if (prev_stall) begin
                chk("stall_hold_valid", tw_valid, 1);
                chk("stall_hold_data", rom_q, prev_rom);
            end
            if (!busy) begin
                chk("idle_valid", tw_valid, 0);
                chk("idle_rd_en", rd_en, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_timing", cyc, last_acc_cyc + 1);
                chk("done_busy", busy, 0);
            end
            prev_stall = tw_valid && !ready;
            prev_rom   = rom_q;
            if (tw_valid && ready) begin
                acc_cnt++;
                if (exp_idx == TOTAL - 1) begin
                    exp_idx      = 0;
                    last_acc_cyc = cyc;
                end else begin
                    exp_idx++;
                end
            end
        end
    end

    // Ready driver: always-ready or random with one forced 4-cycle stall at the pinned element.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                ready = 1'b1;
            end else if (tw_valid && int'(tw_stage) == P2S && int'(tw_idx) == P2J && forced < 4) begin
                ready = 1'b0;
                forced++;
            end else begin
                ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_all_zero("idle");
        end

        // Full run with ready held high and a start pulse while busy.
        acc_cnt  = 0;
        done_cnt = 0;
        pulse_start();
        @(negedge clk);
        chk("lat_busy", busy, 1);
        chk("lat_valid0", tw_valid, 0);
        chk("lat_rd_en", rd_en, 1);
        chk("lat_rd_addr", rd_addr, 0);
        @(negedge clk);
        chk("lat_valid1", tw_valid, 1);
        repeat (97) @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(TOTAL + 200);
        repeat (5) @(negedge clk);
        chk("run1_count", acc_cnt, TOTAL);
        chk("run1_done_cnt", done_cnt, 1);
        chk("run1_done_cyc", done_cyc - start_cyc, TOTAL + 1);
        chk("run1_busy", busy, 0);

        // Random back-pressure with a forced stall.
        mode     = 1;
        acc_cnt  = 0;
        done_cnt = 0;
        pulse_start();
        wait_done(8 * TOTAL);
        repeat (3) @(negedge clk);
        chk("run2_count", acc_cnt, TOTAL);
        chk("run2_done_cnt", done_cnt, 1);
        chk("run2_forced", forced, 4);

        // Reset in the middle of a run, then restart.
        mode     = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        pulse_start();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (acc_cnt >= 2000) break;
        end
        chk("midrst_reached", (acc_cnt >= 2000) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy_now", busy, 0);
        chk("midrst_rd_en_now", rd_en, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_rst");
        acc_cnt  = 0;
        done_cnt = 0;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        chk("restart_valid", tw_valid, 1);
        chk("restart_stage", tw_stage, 0);
        chk("restart_idx", tw_idx, 0);
        wait_done(TOTAL + 200);
        repeat (3) @(negedge clk);
        chk("run3_count", acc_cnt, TOTAL);
        chk("run3_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
